// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin_seq
// Purpose  : Sequential BCD-to-binary converter (reverse double-dabble), one
//            binary bit per cycle, with malformed-digit detection.
// Revision : 1.0  initial release
// ============================================================================
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out
);

    localparam int             CW     = $clog2(BIN_W) + 1;
    localparam logic [CW-1:0]  C_LAST = CW'(BIN_W - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [4*DIGITS-1:0]    bcd_sh_q;
    logic [BIN_W-1:0]       bin_sh_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic [BIN_W-1:0]       bin_out_q;

    logic [4*DIGITS-1:0]    bcd_shr;
    logic [4*DIGITS-1:0]    bcd_sh_d;
    logic [BIN_W-1:0]       bin_sh_d;
    logic [DIGITS-1:0]      digit_bad;

    assign bcd_shr  = bcd_sh_q >> 1;
    assign bin_sh_d = {bcd_sh_q[0], bin_sh_q[BIN_W-1:1]};

    // Correction is applied to the already-shifted digits; a digit >= 8 here
    // means a decimal ten was shifted in from the digit above.
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            logic [3:0] shr_dig;
            assign shr_dig                = bcd_shr[4*i +: 4];
            assign bcd_sh_d[4*i +: 4]     = (shr_dig >= 4'd8) ? (shr_dig - 4'd3) : shr_dig;
            assign digit_bad[i]           = (bcd_in[4*i +: 4] > 4'd9);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bcd_sh_q  <= '0;
            bin_sh_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bin_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (|digit_bad) begin
                            done_q    <= 1'b1;
                            err_q     <= 1'b1;
                            bin_out_q <= '0;
                        end else begin
                            bcd_sh_q <= bcd_in;
                            bin_sh_q <= '0;
                            cnt_q    <= '0;
                            err_q    <= 1'b0;
                            busy_q   <= 1'b1;
                            state_q  <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    bcd_sh_q <= bcd_sh_d;
                    bin_sh_q <= bin_sh_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == C_LAST) begin
                        bin_out_q <= bin_sh_d;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign bin_out = bin_out_q;

endmodule
`default_nettype wire
